// File: rtl/usb_tx_pts_sr.sv
// rtl/usb_tx_pts_sr.sv - USB transmit parallel-to-serial shifter with NRZI line encoding
// Optional bit stuffing (0 after six 1s) is built when USB_TX_BIT_STUFF_EN is defined.
module usb_tx_pts_sr #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift_enable,
   input  logic                load,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                serial_out,
   output logic                ready,
   output logic                byte_sent,
   output logic                busy
);

   localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

`ifdef USB_TX_BIT_STUFF_EN
   typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;
`else
   typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] hold_q, hold_d;
   logic                hold_full_q, hold_full_d;
   logic [NUM_BITS-1:0] sr_q, sr_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                serial_q, serial_d;
   logic                byte_sent_q, byte_sent_d;
`ifdef USB_TX_BIT_STUFF_EN
   logic [2:0]          ones_q, ones_d;
   logic [2:0]          ones_nxt;
`endif

   logic                accept;
   logic                hold_avail;
   logic                data_strobe;
   logic [NUM_BITS-1:0] src;
   logic                bit_v;
   logic                last_bit;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      serial_d    = serial_q;
      byte_sent_d = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
      ones_d      = ones_q;
      ones_nxt    = ones_q;
`endif
      data_strobe = 1'b0;
      src         = sr_q;
      bit_v       = 1'b0;
      last_bit    = 1'b0;

      accept = load && !hold_full_q;
      if (accept) begin
         hold_d      = parallel_in;
         hold_full_d = 1'b1;
      end
      // A load landing on the last-bit edge still counts as a refill for gapless streaming
      hold_avail = hold_full_q || accept;

      if (shift_enable) begin
         case (state_q)
            IDLE: begin
               if (hold_full_q) begin
                  data_strobe = 1'b1;
                  src         = hold_q;
                  hold_full_d = 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt_q != '0) begin
                  data_strobe = 1'b1;
               end else if (hold_full_q) begin
                  data_strobe = 1'b1;
                  src         = hold_q;
                  hold_full_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
`ifdef USB_TX_BIT_STUFF_EN
            STUFF: begin
               serial_d = ~serial_q;
               ones_d   = '0;
               if (bit_cnt_q == '0 && !hold_avail) state_d = IDLE;
               else                                state_d = SHIFT;
            end
`endif
            default: state_d = IDLE;
         endcase

         if (data_strobe) begin
            bit_v       = SHIFT_MSB ? src[NUM_BITS-1] : src[0];
            sr_d        = SHIFT_MSB ? {src[NUM_BITS-2:0], 1'b0} : {1'b0, src[NUM_BITS-1:1]};
            serial_d    = bit_v ? serial_q : ~serial_q;
            last_bit    = (bit_cnt_q == CW'(NUM_BITS - 1));
            bit_cnt_d   = last_bit ? '0 : bit_cnt_q + 1'b1;
            byte_sent_d = last_bit;
`ifdef USB_TX_BIT_STUFF_EN
            ones_nxt = bit_v ? ones_q + 3'd1 : 3'd0;
            ones_d   = ones_nxt;
            if (ones_nxt == 3'd6) begin
               state_d = STUFF;
            end else if (last_bit && !hold_avail) begin
               state_d = IDLE;
               ones_d  = '0;
            end else begin
               state_d = SHIFT;
            end
`else
            if (last_bit && !hold_avail) state_d = IDLE;
            else                         state_d = SHIFT;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         serial_q    <= 1'b1;
         byte_sent_q <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
         ones_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         serial_q    <= serial_d;
         byte_sent_q <= byte_sent_d;
`ifdef USB_TX_BIT_STUFF_EN
         ones_q      <= ones_d;
`endif
      end
   end

   assign serial_out = serial_q;
   assign byte_sent  = byte_sent_q;
   assign ready      = !hold_full_q;
   assign busy       = (state_q != IDLE) || hold_full_q;

endmodule

// File: doc/usb_tx_pts_sr.md
# usb_tx_pts_sr

Parallel-to-serial transmit shifter for the USB link, the transmit-side counterpart of the receive serial-to-parallel path. Accepts one byte at a time through a single-entry holding register. Shifts bits out one per `shift_enable` strobe, with optional bit stuffing, and NRZI-encodes them onto a single line-level output. Sits between the TX packet controller, which supplies bytes, and the bus driver, which drives D+/D- from `serial_out`.

## Interface
Parameters:
- `NUM_BITS`, 8: data bits per transfer unit.
- `SHIFT_MSB`, 0: 1 sends the MSB first; 0 sends the LSB first (USB order).

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `shift_enable`, in, 1: one-cycle strobe per bit time. All line activity happens only on strobe cycles.
- `load`, in, 1: write request for `parallel_in`.
- `parallel_in`, in, NUM_BITS: byte to transmit. Sampled on an accepted `load`.
- `serial_out`, out, 1: NRZI line level. Registered.
- `ready`, out, 1: holding register empty; `load` is accepted this cycle.
- `byte_sent`, out, 1: one-cycle pulse when the last data bit of a byte has been driven.
- `busy`, out, 1: transmitter active or holding register full.

## Operation
- **Storage:** holding register `hold` with flag `hold_full`; shift register; bit counter 0..NUM_BITS-1; ones counter 0..6.
- **Load:** `load && ready` captures `parallel_in` and sets `hold_full`. `load && !ready` is ignored, with no side effects.
- **States:**
  - IDLE → SHIFT on `shift_enable && hold_full`. That same edge moves `hold` into the shift register, clears `hold_full`, and drives the first data bit.
  - SHIFT → STUFF when the just-driven bit made the ones count 6.
  - SHIFT → SHIFT on the last data bit when `hold_full`. This is a back-to-back transfer: `hold` moves in on that next strobe's edge, with no idle bit.
  - SHIFT → IDLE after the last data bit when `!hold_full` and no stuff is pending.
  - STUFF → SHIFT on the next strobe: drive the stuffed 0 and clear the ones count. STUFF → IDLE instead if that stuff bit followed the final bit and `hold` is empty.
- **NRZI:** a data or stuff bit of 0 toggles `serial_out`; a 1 holds it.
- **Ones counter:**
  - increments on each transmitted 1;
  - clears on a transmitted 0 or a stuff bit;
  - carries across byte boundaries;
  - clears on entry to IDLE.
- **Bit order:** set by `SHIFT_MSB`. The bit counter wraps NUM_BITS-1 → 0 at each byte boundary.
- **Outputs:**
  - `busy` = (state != IDLE) || `hold_full`.
  - `ready` = !`hold_full`.
- **Idle level:** in IDLE, `serial_out` holds its last level.

## Timing
- **Reset values:** `serial_out`=1 (J), `ready`=1, `busy`=0, `byte_sent`=0. State is IDLE, counters are 0, `hold_full`=0. A reset mid-byte abandons the byte immediately; there is no partial flush.
- **Line update:** `serial_out` changes only at the edge where `shift_enable` is sampled high. Non-strobe cycles freeze all shift state.
- **Ready timing:** `ready` deasserts the cycle after an accepted `load`. It reasserts the cycle after `hold` transfers to the shift register.
- **Byte duration:** one byte takes NUM_BITS strobes plus one per inserted stuff bit.
- **`byte_sent`:** registered. High for exactly the one cycle after the edge that drives the last data bit, not after a trailing stuff bit.
- **Refill window:** to guarantee a gapless stream, the producer may load the next byte any cycle between `ready` rising and the last-data-bit strobe edge.
- **Stalled strobe:** `shift_enable` held high for several cycles is treated as one strobe per cycle.

## Configuration
- **Macro:** `USB_TX_BIT_STUFF_EN`.
- **Defined:** the STUFF state and the ones counter exist. A 0 is inserted after every 6 consecutive transmitted 1s.
- **Undefined:** no STUFF state and no ones counter. Every strobe in SHIFT drives a data bit, and a byte always takes exactly NUM_BITS strobes.

## Test plan
- **Reset and single 0x00:** reset, then load 0x00 and apply 8 strobes. Expect `serial_out` after each strobe: 0,1,0,1,0,1,0,1. Expect `byte_sent` one cycle after strobe 8, then `busy`=0.
- **Stuffing with 0xFF (macro defined):** load 0xFF. Expect `serial_out` to stay 1 for strobes 1-6, toggle to 0 at strobe 7 (stuff), and stay 0 for strobes 8-9. Expect `byte_sent` after strobe 9. With the macro undefined: 8 strobes, line stays 1.
- **Back-to-back 0xFF, 0xFF (macro defined):** load the second byte when `ready` reasserts. Expect 18 strobes total, stuffs at strobes 7 and 14, no idle bit between bytes, and two `byte_sent` pulses.
- **Load while full:** load 0x12, then load 0x34 while `ready`=0. Expect 0x12 alone to be transmitted, LSB first: 0,1,0,0,1,0,0,0.
- **Reset mid-byte:** assert `rst` after strobe 3 of 0x0F. Expect next-cycle `serial_out`=1, `ready`=1, `busy`=0, and no `byte_sent`. A following 0x00 transmits cleanly.
- **MSB-first build:** with `SHIFT_MSB`=1, load 0x80. Expect the first strobe to hold the line at 1, followed by 7 toggles.
